// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/game-over pauses, lives, rally count and the
// freeze request to the graph block, all timed in video frames.
module pong_game_ctrl #(
  parameter int unsigned BALLS       = 3,
  parameter int unsigned WAIT_FRAMES = 120,
  parameter int unsigned TMR_W       = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       start,
  input  logic       miss,
  input  logic       hit_left,
  input  logic       hit_right,
  output logic       graph_still,
  output logic [1:0] balls_left,
  output logic       game_over,
  output logic [1:0] state_id,
  output logic [7:0] rally,
  output logic       frame_tick
);

  localparam int unsigned RALLY_W = 8;
  localparam logic [TMR_W-1:0]   TMR_LOAD   = TMR_W'(WAIT_FRAMES - 1);
  localparam logic [1:0]         BALLS_INIT = 2'(BALLS);
  localparam logic [RALLY_W-1:0] RALLY_MAX  = {RALLY_W{1'b1}};

  typedef enum logic [1:0] {
    S_NEWGAME = 2'd0,
    S_PLAY    = 2'd1,
    S_NEWBALL = 2'd2,
    S_OVER    = 2'd3
  } state_t;

  state_t             state_q;
  logic [TMR_W-1:0]   timer_q;
  logic [1:0]         balls_q;
  logic [RALLY_W-1:0] rally_q;
  logic               still_q;
  logic               over_q;
  logic               tick_q;
  logic               start_q;
  logic               miss_q;
  logic               hit_q;

  logic frame_match_c;
  logic start_rise_c;
  logic miss_rise_c;
  logic hit_rise_c;

  // Rising edges act on the same clock they are seen.
  assign frame_match_c = (pix_y == 10'd481) && (pix_x == 10'd0);
  assign start_rise_c  = start & ~start_q;
  assign miss_rise_c   = miss & ~miss_q;
  assign hit_rise_c    = (hit_left | hit_right) & ~hit_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_NEWGAME;
      timer_q <= '0;
      balls_q <= BALLS_INIT;
      rally_q <= '0;
      still_q <= 1'b1;
      over_q  <= 1'b0;
      tick_q  <= 1'b0;
      start_q <= 1'b0;
      miss_q  <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      tick_q  <= frame_match_c;
      start_q <= start;
      miss_q  <= miss;
      hit_q   <= hit_left | hit_right;

      case (state_q)
        S_NEWGAME: begin
          if (start_rise_c) begin
            state_q <= S_PLAY;
            still_q <= 1'b0;
            rally_q <= '0;
          end
        end

        S_PLAY: begin
          // A miss wins over a simultaneous hit.
          if (miss_rise_c) begin
            timer_q <= TMR_LOAD;
            still_q <= 1'b1;
            if (balls_q <= 2'd1) begin
              balls_q <= 2'd0;
              state_q <= S_OVER;
              over_q  <= 1'b1;
            end else begin
              balls_q <= balls_q - 2'd1;
              state_q <= S_NEWBALL;
            end
          end else if (hit_rise_c && (rally_q != RALLY_MAX)) begin
            rally_q <= rally_q + RALLY_W'(1);
          end
        end

        S_NEWBALL: begin
          if (tick_q) begin
            if (timer_q == '0) begin
              state_q <= S_PLAY;
              still_q <= 1'b0;
              rally_q <= '0;
            end else begin
              timer_q <= timer_q - TMR_W'(1);
            end
          end
        end

        S_OVER: begin
          if (tick_q) begin
            if (timer_q == '0) begin
              state_q <= S_NEWGAME;
              balls_q <= BALLS_INIT;
              over_q  <= 1'b0;
              still_q <= 1'b1;
              rally_q <= '0;
            end else begin
              timer_q <= timer_q - TMR_W'(1);
            end
          end
        end

        default: begin
          state_q <= S_NEWGAME;
          still_q <= 1'b1;
          over_q  <= 1'b0;
        end
      endcase
    end
  end

  assign graph_still = still_q;
  assign balls_left  = balls_q;
  assign game_over   = over_q;
  assign state_id    = state_q;
  assign rally       = rally_q;
  assign frame_tick  = tick_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with a short 4-frame pause.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       start;
  logic       miss;
  logic       hit_left;
  logic       hit_right;
  logic       graph_still;
  logic [1:0] balls_left;
  logic       game_over;
  logic [1:0] state_id;
  logic [7:0] rally;
  logic       frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  pong_game_ctrl #(
    .BALLS      (3),
    .WAIT_FRAMES(4),
    .TMR_W      (7)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .start      (start),
    .miss       (miss),
    .hit_left   (hit_left),
    .hit_right  (hit_right),
    .graph_still(graph_still),
    .balls_left (balls_left),
    .game_over  (game_over),
    .state_id   (state_id),
    .rally      (rally),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hit_pulse(input bit right);
    if (right) hit_right = 1'b1; else hit_left = 1'b1;
    step();
    hit_left  = 1'b0;
    hit_right = 1'b0;
    step();
  endtask

  // One frame match; returns after the FSM has consumed the tick.
  task automatic frame();
    pix_y = 10'd481;
    pix_x = 10'd0;
    step();
    pix_y = 10'd0;
    pix_x = 10'd5;
    check("frame_tick_hi", 32'(frame_tick), 32'd1);
    step();
    check("frame_tick_lo", 32'(frame_tick), 32'd0);
  endtask

  initial begin
    reset = 1'b1; pix_x = 10'd5; pix_y = 10'd0;
    start = 1'b0; miss = 1'b0; hit_left = 1'b0; hit_right = 1'b0;
    step(); step();
    reset = 1'b0;
    step();

    // Reset state
    check("rst_state", 32'(state_id), 32'd0);
    check("rst_still", 32'(graph_still), 32'd1);
    check("rst_balls", 32'(balls_left), 32'd3);
    check("rst_rally", 32'(rally), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);

    // Non-matching pixel must not tick
    pix_y = 10'd481; pix_x = 10'd1;
    step(); step();
    check("no_tick_x1", 32'(frame_tick), 32'd0);
    pix_y = 10'd0; pix_x = 10'd5;

    // Start, then hold it: a single transition
    start = 1'b1;
    step();
    check("start_state", 32'(state_id), 32'd1);
    check("start_still", 32'(graph_still), 32'd0);
    repeat (100) step();
    check("start_held", 32'(state_id), 32'd1);
    start = 1'b0;
    step();

    // Three hits then a miss
    repeat (3) hit_pulse(1'b0);
    check("rally3", 32'(rally), 32'd3);
    miss = 1'b1;
    step();
    miss = 1'b0;
    check("miss1_rally", 32'(rally), 32'd3);
    check("miss1_balls", 32'(balls_left), 32'd2);
    check("miss1_state", 32'(state_id), 32'd2);
    check("miss1_still", 32'(graph_still), 32'd1);
    step();
    for (int i = 0; i < 3; i++) begin
      frame();
      check("pause1_state", 32'(state_id), 32'd2);
    end
    frame();
    check("serve1_state", 32'(state_id), 32'd1);
    check("serve1_rally", 32'(rally), 32'd0);
    check("serve1_still", 32'(graph_still), 32'd0);

    // Simultaneous miss and hit with rally 5; miss then held through re-entry
    repeat (5) hit_pulse(1'b1);
    check("rally5", 32'(rally), 32'd5);
    miss = 1'b1; hit_right = 1'b1;
    step();
    hit_right = 1'b0;
    check("both_rally", 32'(rally), 32'd5);
    check("both_balls", 32'(balls_left), 32'd1);
    check("both_state", 32'(state_id), 32'd2);
    for (int i = 0; i < 4; i++) frame();
    check("serve2_state", 32'(state_id), 32'd1);
    repeat (3) step();
    check("held_miss_state", 32'(state_id), 32'd1);
    check("held_miss_balls", 32'(balls_left), 32'd1);
    miss = 1'b0;
    step();

    // Rally saturation
    for (int i = 0; i < 300; i++) hit_pulse(i[0]);
    check("rally_sat", 32'(rally), 32'd255);

    // Last ball; start held through the game-over pause
    start = 1'b1;
    miss = 1'b1;
    step();
    miss = 1'b0;
    check("over_state", 32'(state_id), 32'd3);
    check("over_balls", 32'(balls_left), 32'd0);
    check("over_flag", 32'(game_over), 32'd1);
    check("over_rally", 32'(rally), 32'd255);
    step();
    for (int i = 0; i < 3; i++) begin
      frame();
      check("over_wait", 32'(state_id), 32'd3);
    end
    frame();
    check("newgame_state", 32'(state_id), 32'd0);
    check("newgame_balls", 32'(balls_left), 32'd3);
    check("newgame_over", 32'(game_over), 32'd0);
    check("newgame_still", 32'(graph_still), 32'd1);
    repeat (3) step();
    check("start_held_ng", 32'(state_id), 32'd0);
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_state", 32'(state_id), 32'd1);
    step();

    // Asynchronous reset in the middle of a NEWBALL pause
    miss = 1'b1;
    step();
    miss = 1'b0;
    check("nb_state", 32'(state_id), 32'd2);
    step();
    frame();
    reset = 1'b1;
    #1;
    check("async_state", 32'(state_id), 32'd0);
    check("async_balls", 32'(balls_left), 32'd3);
    check("async_still", 32'(graph_still), 32'd1);
    start = 1'b1;
    step();
    reset = 1'b0;
    step();
    start = 1'b0;
    check("post_rst_start", 32'(state_id), 32'd1);
    step();

    // Full pause length after reset
    miss = 1'b1;
    step();
    miss = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      frame();
      check("pause3_state", 32'(state_id), 32'd2);
    end
    frame();
    check("serve3_state", 32'(state_id), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
- Top-level game sequencer for the pong datapath. It drives the graph block's `graph_still` freeze input and consumes its `miss`, `hit_left` and `hit_right` flags.
- It tracks the remaining balls (lives), times the serve and game-over pauses in video frames, and counts rally hits.
- It exports a state code for the text/overlay logic.
- It sits between the VGA sync generator, the buttons and the graph block.

Parameters:
- BALLS, 3, balls per game (1..3).
- WAIT_FRAMES, 120, pause length in frames (2 s at 60 Hz); range 1..128.
- TMR_W, 7, timer width; must hold WAIT_FRAMES-1.

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  reset, asynchronous, active-high
- pix_x  in  10  current pixel column from sync generator
- pix_y  in  10  current pixel row from sync generator
- start  in  1  start/serve button, synchronous, level
- miss  in  1  miss flag from graph block, level
- hit_left  in  1  left-paddle hit flag from graph block, level
- hit_right  in  1  right-paddle hit flag from graph block, level
- graph_still  out  1  freeze/recentre request to graph block, registered
- balls_left  out  2  balls remaining, registered
- game_over  out  1  high while in OVER, registered
- state_id  out  2  0=NEWGAME 1=PLAY 2=NEWBALL 3=OVER, registered
- rally  out  8  paddle hits since last serve, saturating, registered
- frame_tick  out  1  one-clk pulse per frame, registered

Behaviour:
- Reset (async, any state, including mid-pause):
  - state=NEWGAME, graph_still=1, balls_left=BALLS, game_over=0, rally=0, frame_tick=0.
  - Timer=0 and all edge-detect registers=0.
- Frame tick: `frame_tick` registers the match (pix_y==481 && pix_x==0). It pulses for one clk, one clk after the match.
- Edge detection: one register each for start, miss and (hit_left|hit_right).
  - start_rise = start & ~start_q; likewise miss_rise and hit_rise.
  - Each rise is one clk wide and is evaluated on the same clk it is detected.
- Registered outputs: all outputs update on the clk edge that performs the transition. There is no combinational path from inputs to outputs.
- NEWGAME:
  - graph_still=1, balls_left=BALLS, rally=0, state_id=0.
  - start_rise -> PLAY.
- PLAY:
  - graph_still=0, state_id=1.
  - hit_rise with no miss_rise: rally+1, saturating at 255.
  - miss_rise with balls_left==1: balls_left=0, go to OVER, load timer=WAIT_FRAMES-1.
  - miss_rise with balls_left>1: balls_left-1, go to NEWBALL, load timer=WAIT_FRAMES-1.
  - miss_rise and hit_rise on the same clk: the miss is processed; rally is not incremented.
  - start is ignored in PLAY.
- NEWBALL:
  - graph_still=1, state_id=2.
  - On each frame_tick: if timer==0, go to PLAY and clear rally; otherwise decrement the timer.
  - The pause therefore lasts exactly WAIT_FRAMES frame_ticks.
  - start and miss are ignored.
- OVER:
  - graph_still=1, game_over=1, state_id=3.
  - Same timer rule as NEWBALL; expiry goes to NEWGAME (balls_left reloads to BALLS on entry).
  - start is ignored, so a start held through expiry does not launch a game until it is released and pressed again.
- Held level inputs: a miss level still high when PLAY is re-entered has no effect, because only rising edges act. miss_q/hit_q keep sampling in every state.
- rally is not cleared by a miss. It holds its value through NEWBALL/OVER for display and clears when PLAY is entered.
- Timer is a TMR_W-bit down-counter. It never wraps below 0, and it is only decremented on frame_tick.

Test Plan:
1. Reset then release (BALLS=3) -> state_id=0, graph_still=1, balls_left=3, rally=0; assert reset during NEWBALL countdown -> NEWGAME within the same clk, timer=0.
2. start pulse in NEWGAME -> next clk state_id=1, graph_still=0; start held high 100 clks -> only one transition.
3. In PLAY, 3 hit_left rising edges then a miss edge (WAIT_FRAMES=4) -> rally=3, balls_left=2, state_id=2, graph_still=1; PLAY re-entered exactly on the 4th frame_tick with rally=0.
4. Three misses total -> balls_left 3->2->1->0, state_id=3, game_over=1; after 4 frame_ticks state_id=0 and balls_left=3, even with start held high throughout.
5. miss and hit_right rising on the same clk with rally=5 -> rally stays 5, balls_left decrements by 1.
6. 300 hit edges in one rally -> rally saturates at 255, no wrap; frame_tick pulses exactly once per pix_y=481/pix_x=0 match.
